pkt_tx_framer: RTL and testbench
================================

# pkt_tx_framer

Transmit-side framer for the Q-routing node. When the routing core reports `done`, the block captures the outgoing packet fields (source ID, cluster ID, battery status, Q value, destination ID) and the aggregation flag. It then serializes them as a byte frame onto the radio link interface, using a valid/ready handshake, a running checksum and an enforced inter-frame gap. It is the counterpart of the receive path that feeds the core's `f*` inputs.

## Interface
- `WORD_WIDTH`, 16, width of each packet field (fixed at 16; frame layout depends on it)
- `SOF_BYTE`, 8'h7E, start-of-frame marker
- `IFG_CYCLES`, 2, idle cycles enforced after each frame (0 allowed)
- `clock` in 1, rising-edge clock
- `nrst` in 1, reset: synchronous, active-low
- `start` in 1, one-cycle pulse from core `done`
- `for_agg` in 1, core `forAggregation`, sampled with `start`
- `src_id`, `clus_id`, `batt`, `qval`, `dest_id` in 16 each, packet fields, sampled with `start`
- `tx_data` out 8, current frame byte
- `tx_valid` out 1, `tx_data` is valid
- `tx_ready` in 1, link accepts the byte on this edge when `tx_valid` is high
- `busy` out 1, a frame is in progress or the IFG is running
- `tx_done` out 1, one-cycle pulse after the checksum byte is accepted
- `drop_cnt` out 8, saturating count of `start` pulses ignored while busy

## Operation
- Frame is 13 bytes, in this order: SOF, TYPE, src_id[15:8], src_id[7:0], clus_id hi/lo, batt hi/lo, qval hi/lo, dest_id hi/lo, CHK.
- TYPE = 8'h01 when `for_agg`=0 (forward); TYPE = 8'h02 when `for_agg`=1 (aggregation notice).
- CHK = XOR of TYPE and the 10 payload bytes. SOF is excluded.
- States and transitions:
  - IDLE → SOF on `start`.
  - SOF → TYPE on accept.
  - TYPE → PAYLOAD on accept.
  - PAYLOAD → CHK after the 10th byte is accepted.
  - CHK → GAP on accept, or → IDLE directly when IFG_CYCLES=0.
  - GAP → IDLE after IFG_CYCLES cycles.
- PAYLOAD uses a 4-bit byte index, 0..9. The index selects the byte from the captured 80-bit field register.
- Accept = `tx_valid & tx_ready` at a rising edge. `tx_data` and `tx_valid` are held stable until accept; no byte is ever retracted.
- `start` is honoured only in IDLE. In all other states it is dropped and `drop_cnt` increments, saturating at 8'hFF.
- Input fields are captured into internal registers on an accepted `start`. Later changes on the inputs do not affect the frame in flight.
- `busy` is high in every state except IDLE.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `tx_done`=0, `drop_cnt`=0, state IDLE, checksum accumulator 0.
- `start` is seen at edge N. At edge N+1, `tx_valid`=1, `tx_data`=SOF and `busy`=1.
- Each byte advances on the edge after which its accept occurred. With `tx_ready` held high, one byte goes out per cycle: the SOF→CHK span is 13 cycles.
- `tx_done` is high for the one cycle following the CHK accept. `tx_valid` drops in that same cycle.
- GAP lasts exactly IFG_CYCLES cycles with `tx_valid`=0. A `start` in the first IDLE cycle after GAP is honoured.
- With `tx_ready` high, minimum `start`-to-`start` spacing is 14 + IFG_CYCLES cycles.
- `start` in the same cycle as the CHK accept or during GAP: dropped and counted.
- `nrst` low mid-frame: at the next edge all outputs return to their reset values. The partial frame is abandoned and no `tx_done` is produced.
- Checksum accumulator: cleared on leaving IDLE, updated with each accepted TYPE and PAYLOAD byte.

## Structure
- Package `pkt_tx_pkg` holds:
  - the state enum (IDLE, SOF, TYPE, PAYLOAD, CHK, GAP);
  - TYPE_FWD=8'h01 and TYPE_AGG=8'h02;
  - FRAME_LEN=13 and PAYLOAD_BYTES=10.
- One sub-module, `pkt_tx_chk`: an 8-bit XOR accumulator with clear and update-enable inputs. It is reused by the receive-side checker.

## Test plan
- Basic frame: src=3, clus=1, batt=16'h8000, qval=16'h1234, dest=16'h0009, for_agg=0, `tx_ready`=1.
  - Required bytes: 7E 01 00 03 00 01 80 00 12 34 00 09 AC.
  - `tx_done` one cycle after AC; `busy` low 2 cycles later.
- Same fields with for_agg=1: TYPE byte = 02 and CHK = AF.
- Backpressure: drive `tx_ready` low for 3 cycles on each odd byte.
  - Each byte must be held stable until accepted.
  - Byte sequence identical to the basic-frame case; total duration 13+18 cycles.
- Overflow: pulse `start` mid-PAYLOAD and again during GAP.
  - `drop_cnt`=2 and the frame is unchanged.
  - 300 dropped pulses must leave `drop_cnt` = FF.
- Reset mid-frame: assert `nrst` after the 5th byte.
  - All outputs at reset values next edge; no `tx_done`.
  - A new `start` then sends a complete, correct frame.
- IFG_CYCLES=0: two `start` pulses 14 cycles apart are both sent back-to-back with no drops.

Source files
------------

// File: rtl/pkt_tx_pkg.sv
// Shared definitions for the transmit framer and the receive-side checker.
package pkt_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SOF     = 3'd1,
        TYPE    = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        GAP     = 3'd5
    } tx_state_e;

    localparam logic [7:0] TYPE_FWD      = 8'h01;
    localparam logic [7:0] TYPE_AGG      = 8'h02;
    localparam int         FRAME_LEN     = 13;
    localparam int         PAYLOAD_BYTES = 10;

    // Byte idx (0 = most significant) of the 80-bit captured field register.
    function automatic logic [7:0] payload_byte(input logic [79:0] fields,
                                                input logic [3:0]  idx);
        logic [79:0] shifted;
        shifted = fields << ({3'b000, idx} * 7'd8);
        return shifted[79:72];
    endfunction

endpackage

// File: rtl/pkt_tx_framer_if.sv
// Byte-wide valid/ready radio link between the framer and the PHY.
interface pkt_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/pkt_tx_chk.sv
// 8-bit running XOR checksum with clear (priority) and update enable.
module pkt_tx_chk (
    input  logic       clock,
    input  logic       nrst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] acc_o
);
    logic [7:0] acc_q;

    // Accumulator register: synchronous reset, clear wins over update.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            acc_q <= 8'h00;
        end else if (clr_i) begin
            acc_q <= 8'h00;
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end else begin
            acc_q <= acc_q;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/pkt_tx_framer.sv
// Captures a routing-core packet on start and emits it as a 13-byte
// checksummed frame over a valid/ready link, followed by an idle gap.
module pkt_tx_framer
    import pkt_tx_pkg::*;
#(
    parameter int         WORD_WIDTH = 16,
    parameter logic [7:0] SOF_BYTE   = 8'h7E,
    parameter int         IFG_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  for_agg,
    input  logic [WORD_WIDTH-1:0] src_id,
    input  logic [WORD_WIDTH-1:0] clus_id,
    input  logic [WORD_WIDTH-1:0] batt,
    input  logic [WORD_WIDTH-1:0] qval,
    input  logic [WORD_WIDTH-1:0] dest_id,
    pkt_tx_framer_if.master       tx_if,
    output logic                  busy,
    output logic                  tx_done,
    output logic [7:0]            drop_cnt
);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    tx_state_e        state_q, state_d;
    logic [79:0]      fields_q, fields_d;
    logic [7:0]       type_q, type_d;
    logic [3:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_done_q, tx_done_d;
    logic             busy_q, busy_d;
    logic [7:0]       drop_q, drop_d;
    logic             accept_s;
    logic             chk_clr_s;
    logic             chk_en_s;
    logic [7:0]       chk_acc_s;

    assign accept_s = tx_valid_q & tx_if.tx_ready;

    pkt_tx_chk u_chk (
        .clock  (clock),
        .nrst   (nrst),
        .clr_i  (chk_clr_s),
        .en_i   (chk_en_s),
        .data_i (tx_data_q),
        .acc_o  (chk_acc_s)
    );

    // Next-state, next-output and drop-counter logic of the frame FSM.
    always_comb begin
        state_d    = state_q;
        fields_d   = fields_q;
        type_d     = type_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_done_d  = 1'b0;
        drop_d     = drop_q;
        chk_clr_s  = 1'b0;
        chk_en_s   = 1'b0;

        if (start && (state_q != IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SOF;
                    fields_d   = {src_id, clus_id, batt, qval, dest_id};
                    type_d     = for_agg ? TYPE_AGG : TYPE_FWD;
                    tx_data_d  = SOF_BYTE;
                    tx_valid_d = 1'b1;
                    chk_clr_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SOF: begin
                if (accept_s) begin
                    state_d   = TYPE;
                    tx_data_d = type_q;
                end else begin
                    state_d = SOF;
                end
            end
            TYPE: begin
                if (accept_s) begin
                    state_d   = PAYLOAD;
                    chk_en_s  = 1'b1;
                    idx_d     = 4'd0;
                    tx_data_d = payload_byte(fields_q, 4'd0);
                end else begin
                    state_d = TYPE;
                end
            end
            PAYLOAD: begin
                if (accept_s) begin
                    chk_en_s = 1'b1;
                    if (idx_q == 4'(PAYLOAD_BYTES - 1)) begin
                        // Accumulator absorbs this byte on the same edge.
                        state_d   = CHK;
                        tx_data_d = chk_acc_s ^ tx_data_q;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = payload_byte(fields_q, idx_q + 4'd1);
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
            CHK: begin
                if (accept_s) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    tx_done_d  = 1'b1;
                    if (IFG_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(IFG_CYCLES - 1);
                    end
                end else begin
                    state_d = CHK;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q    <= IDLE;
            fields_q   <= 80'h0;
            type_q     <= 8'h00;
            idx_q      <= 4'd0;
            gap_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            fields_q   <= fields_d;
            type_q     <= type_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_if.tx_data  = tx_data_q;
    assign tx_if.tx_valid = tx_valid_q;
    assign busy           = busy_q;
    assign tx_done        = tx_done_q;
    assign drop_cnt       = drop_q;
endmodule

// File: tb/tb_pkt_tx_framer.sv
// Directed bench for pkt_tx_framer: table of packets with hand-computed
// checksums, plus sequences for backpressure, drops, reset and zero IFG.
module tb_pkt_tx_framer;
    import pkt_tx_pkg::*;

    typedef struct {
        logic        agg;
        logic [15:0] src;
        logic [15:0] clus;
        logic [15:0] batt;
        logic [15:0] qval;
        logic [15:0] dest;
        logic [7:0]  chk;
    } vec_t;

    logic        clock;
    logic        nrst;
    logic        start;
    logic        for_agg;
    logic [15:0] src_id, clus_id, batt, qval, dest_id;
    logic        busy, tx_done, busy0, tx_done0;
    logic [7:0]  drop_cnt, drop_cnt0;

    pkt_tx_framer_if tx_if ();
    pkt_tx_framer_if tx_if0 ();

    pkt_tx_framer #(.WORD_WIDTH(16), .SOF_BYTE(8'h7E), .IFG_CYCLES(2)) dut (
        .clock(clock), .nrst(nrst), .start(start), .for_agg(for_agg),
        .src_id(src_id), .clus_id(clus_id), .batt(batt), .qval(qval),
        .dest_id(dest_id), .tx_if(tx_if), .busy(busy), .tx_done(tx_done),
        .drop_cnt(drop_cnt)
    );

    pkt_tx_framer #(.WORD_WIDTH(16), .SOF_BYTE(8'h7E), .IFG_CYCLES(0)) dut0 (
        .clock(clock), .nrst(nrst), .start(start), .for_agg(for_agg),
        .src_id(src_id), .clus_id(clus_id), .batt(batt), .qval(qval),
        .dest_id(dest_id), .tx_if(tx_if0), .busy(busy0), .tx_done(tx_done0),
        .drop_cnt(drop_cnt0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [103:0] exp_frame(input vec_t v);
        return {8'h7E, (v.agg ? 8'h02 : 8'h01), v.src, v.clus, v.batt, v.qval, v.dest, v.chk};
    endfunction

    task automatic apply_fields(input vec_t v);
        for_agg = v.agg; src_id = v.src; clus_id = v.clus;
        batt = v.batt; qval = v.qval; dest_id = v.dest;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Launch a frame and consume stop_after bytes, checking data and hold.
    task automatic run_frame(input vec_t v, input bit bp, input int pulse_at,
                             input int stop_after, input int exp_cycles);
        logic [103:0] f;
        logic [7:0]   held;
        int           nb, cyc, hold;
        bit           pend;
        f = exp_frame(v);
        apply_fields(v);
        pulse_start();
        src_id = ~v.src; qval = v.qval ^ 16'h5A5A; for_agg = ~v.agg;
        nb = 0; cyc = 0; hold = 0; pend = 1'b0; held = 8'h00;
        while (nb < stop_after && cyc < 200) begin
            if (pend) begin
                check("hold_valid", 32'(tx_if.tx_valid), 32'd1);
                check("hold_data", 32'(tx_if.tx_data), 32'(held));
            end
            if (bp && nb[0] && hold < 3) begin
                tx_if.tx_ready = 1'b0;
                hold++;
            end else begin
                tx_if.tx_ready = 1'b1;
            end
            start = (cyc == pulse_at);
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                check($sformatf("byte%0d", nb), 32'(tx_if.tx_data), 32'(f[103-8*nb -: 8]));
                nb++;
                hold = 0;
                pend = 1'b0;
            end else begin
                pend = tx_if.tx_valid;
                held = tx_if.tx_data;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        tx_if.tx_ready = 1'b1;
        check("frame_bytes", 32'(nb), 32'(stop_after));
        if (exp_cycles > 0) check("frame_cycles", 32'(cyc), 32'(exp_cycles));
    endtask

    // After the CHK accept: done pulse, two gap cycles, then idle.
    task automatic post_frame(input bit gap_pulse);
        check("done_pulse", 32'(tx_done), 32'd1);
        check("valid_drop", 32'(tx_if.tx_valid), 32'd0);
        check("busy_gap1", 32'(busy), 32'd1);
        start = gap_pulse;
        tick();
        start = 1'b0;
        check("done_single", 32'(tx_done), 32'd0);
        check("busy_gap2", 32'(busy), 32'd1);
        tick();
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0]   got0[26];
        logic [103:0] f0, f1;
        int           nb, dones, w;

        vecs[0] = '{1'b0, 16'h0003, 16'h0001, 16'h8000, 16'h1234, 16'h0009, 8'hAC};
        vecs[1] = '{1'b1, 16'h0003, 16'h0001, 16'h8000, 16'h1234, 16'h0009, 8'hAF};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h01};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h02};
        vecs[4] = '{1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 8'h01};
        vecs[5] = '{1'b1, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000, 16'h005A, 8'h58};

        nrst = 1'b0; start = 1'b0; for_agg = 1'b0;
        src_id = 16'h0; clus_id = 16'h0; batt = 16'h0; qval = 16'h0; dest_id = 16'h0;
        tx_if.tx_ready = 1'b1;
        tx_if0.tx_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(tx_if.tx_valid), 32'd0);
        check("rst_data", 32'(tx_if.tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        nrst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 1'b0, -1, FRAME_LEN, 13);
            post_frame(1'b0);
            check("no_drops", 32'(drop_cnt), 32'd0);
        end

        // Backpressure on every odd byte.
        run_frame(vecs[0], 1'b1, -1, FRAME_LEN, 31);
        post_frame(1'b0);

        // start mid-PAYLOAD and during GAP are both dropped.
        run_frame(vecs[0], 1'b0, 6, FRAME_LEN, 13);
        post_frame(1'b1);
        check("drop_two", 32'(drop_cnt), 32'd2);

        // Hold start for 300 cycles: the counter saturates.
        start = 1'b1;
        repeat (300) tick();
        start = 1'b0;
        w = 0;
        while (busy && w < 40) begin
            tick();
            w++;
        end
        check("idle_after_flood", 32'(busy), 32'd0);
        check("drop_sat", 32'(drop_cnt), 32'hFF);

        // Reset after the 5th byte.
        run_frame(vecs[4], 1'b0, -1, 5, 0);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("mid_rst_valid", 32'(tx_if.tx_valid), 32'd0);
        check("mid_rst_data", 32'(tx_if.tx_data), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(tx_done), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_done || tx_if.tx_valid) dones++;
            tick();
        end
        check("abandoned_frame", 32'(dones), 32'd0);
        run_frame(vecs[4], 1'b0, -1, FRAME_LEN, 13);
        post_frame(1'b0);

        // Zero inter-frame gap: starts 14 cycles apart, back-to-back frames.
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        apply_fields(vecs[0]);
        pulse_start();
        nb = 0;
        dones = 0;
        for (int i = 0; i < 27; i++) begin
            start = (i == 13);
            if (i == 13) apply_fields(vecs[1]);
            if (tx_if0.tx_valid) begin
                if (nb < 26) got0[nb] = tx_if0.tx_data;
                nb++;
            end
            if (tx_done0) dones++;
            tick();
        end
        start = 1'b0;
        check("ifg0_bytes", 32'(nb), 32'd26);
        check("ifg0_first_done", 32'(dones), 32'd1);
        check("ifg0_second_done", 32'(tx_done0), 32'd1);
        check("ifg0_drops", 32'(drop_cnt0), 32'd0);
        f0 = exp_frame(vecs[0]);
        f1 = exp_frame(vecs[1]);
        for (int k = 0; k < 13; k++) begin
            check($sformatf("ifg0_f0_byte%0d", k), 32'(got0[k]), 32'(f0[103-8*k -: 8]));
            check($sformatf("ifg0_f1_byte%0d", k), 32'(got0[13+k]), 32'(f1[103-8*k -: 8]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
